// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the port arbiter: one request/acknowledge channel to a
// single-ported memory.
//
// Handshake: mem_req is raised by the master and held, together with mem_we,
// mem_addr and mem_wdata, completely stable until the slave answers with a
// single-cycle mem_ack pulse. mem_rdata is valid only in that mem_ack cycle.
// The master drops mem_req in the cycle after the ack. At most one request is
// outstanding. A mem_ack while no request is pending is ignored.
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports
// of the pipeline. Each port keeps a one-entry result buffer tagged with the
// address it was fetched for; results are held until both ports are ready in
// the same cycle (advance), which is when the pipeline consumes them.
module mem_port_arbiter #(
  parameter bit D_FIRST   = 1'b1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          icache_addr,
  output logic [31:0]          icache_data,
  output logic                 icache_rdy,
  input  logic [31:0]          dcache_addr,
  input  logic [31:0]          dcache_wdata,
  input  logic                 dcache_en,
  input  logic                 dcache_wr,
  output logic [31:0]          dcache_rdata,
  output logic                 dcache_rdy,
  mem_port_arbiter_if.master   mem,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   i_done_q, i_done_d;
  logic                   d_done_q, d_done_d;
  logic [31:0]            i_buf_q, i_buf_d;
  logic [31:0]            d_buf_q, d_buf_d;
  logic [31:0]            i_tag_q, i_tag_d;
  logic [31:0]            d_tag_q, d_tag_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic i_hit;
  logic d_hit;
  logic advance;
  logic i_keep;
  logic d_keep;
  logic i_need;
  logic d_need;

  // Readiness, advance and the pending flags the IDLE decision works from.
  // A done entry survives only if its tag still matches the current address
  // and the pipeline is not consuming it on this edge; a stale entry counts
  // as not done, so the port is re-issued.
  always_comb begin
    i_hit      = i_done_q && (i_tag_q == icache_addr);
    d_hit      = d_done_q && (d_tag_q == dcache_addr);
    icache_rdy = i_hit;
    dcache_rdy = !dcache_en || d_hit;
    advance    = icache_rdy && dcache_rdy;
    i_keep     = i_hit && !advance;
    d_keep     = d_hit && !advance;
    i_need     = !i_keep;
    d_need     = dcache_en && !d_keep;
  end

  // Next-state logic for the sequencer, result buffers and stall counter.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = i_done_q;
    d_done_d    = d_done_q;
    i_buf_d     = i_buf_q;
    d_buf_d     = d_buf_q;
    i_tag_d     = i_tag_q;
    d_tag_d     = d_tag_q;
    stall_cnt_d = advance ? stall_cnt_q : stall_cnt_q + CNT_WIDTH'(1);

    if (advance) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Stale or consumed entries are dropped here; matching ones are kept.
        i_done_d = i_keep;
        d_done_d = d_keep;
        if (d_need && (D_FIRST || !i_need)) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dcache_wr;
          mem_addr_d  = dcache_addr;
          mem_wdata_d = dcache_wdata;
          d_tag_d     = dcache_addr;
          d_done_d    = 1'b0;
        end else if (i_need) begin
          state_d    = I_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = icache_addr;
          i_tag_d    = icache_addr;
          i_done_d   = 1'b0;
        end
      end
      I_BUSY: begin
        if (mem.mem_ack) begin
          i_buf_d   = mem.mem_rdata;
          i_done_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      D_BUSY: begin
        // Stores capture mem_rdata too; the value is simply never used.
        if (mem.mem_ack) begin
          d_buf_d   = mem.mem_rdata;
          d_done_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State register; reset wins over advance and mem_ack in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_buf_q     <= '0;
      d_buf_q     <= '0;
      i_tag_q     <= '0;
      d_tag_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_buf_q     <= i_buf_d;
      d_buf_q     <= d_buf_d;
      i_tag_q     <= i_tag_d;
      d_tag_q     <= d_tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    mem.mem_req   = mem_req_q;
    mem.mem_we    = mem_we_q;
    mem.mem_addr  = mem_addr_q;
    mem.mem_wdata = mem_wdata_q;
    icache_data   = i_buf_q;
    dcache_rdata  = d_buf_q;
    stall_cnt     = stall_cnt_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench plays the memory: expected
// requests are queued in req_q when a scenario is set up and checked when the
// DUT raises mem_req; expected read results are queued in exp_q when the ack
// data is driven and checked when the matching rdy flag is seen.
module tb_mem_port_arbiter;

  // Clock and reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_rdy;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic        dcache_en;
  logic        dcache_wr;
  logic [31:0] dcache_rdata;
  logic        dcache_rdy;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_state;

  mem_port_arbiter_if mem_if();

  mem_port_arbiter #(
    .D_FIRST   (1'b1),
    .CNT_WIDTH (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_rdy   (icache_rdy),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_en    (dcache_en),
    .dcache_wr    (dcache_wr),
    .dcache_rdata (dcache_rdata),
    .dcache_rdy   (dcache_rdy),
    .mem          (mem_if),
    .stall_cnt    (stall_cnt),
    .dbg_state    (dbg_state)
  );

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [64:0] req_q[$];  // {we, addr, wdata}
  logic [31:0] exp_q[$];  // expected read results in order of return

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [64:0] req(input logic we, input logic [31:0] a, input logic [31:0] w);
    return {we, a, w};
  endfunction

  // Wait (bounded) for mem_req, compare against the next queued request, then
  // hold off the ack for 'waits' cycles while checking the request is stable.
  task automatic await_req(input int waits);
    int          n;
    logic [64:0] r;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] w0;
    n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_seen", mem_if.mem_req, 1);
    checks++;
    assert (req_q.size() != 0) else begin
      errors++;
      $error("FAIL req_queue observed=unexpected_request expected=none");
    end
    r = (req_q.size() != 0) ? req_q.pop_front() : '0;
    check("req_we", mem_if.mem_we, r[64]);
    check("req_addr", mem_if.mem_addr, r[63:32]);
    if (r[64]) check("req_wdata", mem_if.mem_wdata, r[31:0]);
    we0 = mem_if.mem_we;
    a0  = mem_if.mem_addr;
    w0  = mem_if.mem_wdata;
    for (int k = 0; k < waits; k++) begin
      @(negedge clock);
      check("hold_req", mem_if.mem_req, 1);
      check("hold_we", mem_if.mem_we, we0);
      check("hold_addr", mem_if.mem_addr, a0);
      check("hold_wdata", mem_if.mem_wdata, w0);
    end
  endtask

  // One-cycle ack; returns in the cycle after the ack.
  task automatic give_ack(input logic [31:0] rdata);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = rdata;
    @(negedge clock);
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = $urandom;
    check("req_drop", mem_if.mem_req, 0);
  endtask

  task automatic set_inputs(input logic [31:0] ia, input logic en, input logic wr,
                            input logic [31:0] da, input logic [31:0] wd);
    icache_addr  = ia;
    dcache_en    = en;
    dcache_wr    = wr;
    dcache_addr  = da;
    dcache_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    logic [31:0] e;
    logic [31:0] dexp;
    logic [31:0] r;

    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    set_inputs(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_wdata", mem_if.mem_wdata, 0);
    check("rst_icache_rdy", icache_rdy, 0);
    check("rst_dcache_rdy_noen", dcache_rdy, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_state", dbg_state, 0);
    dcache_en = 1'b1;
    #1;
    check("rst_dcache_rdy_en", dcache_rdy, 0);
    dcache_en = 1'b0;

    // Solo fetch, zero-wait memory
    reset = 1'b0;
    req_q.push_back(req(1'b0, 32'h0, 32'h0));
    exp_q.push_back(32'h0000_0013);
    tick(1);
    check("t1_req_cycle1", mem_if.mem_req, 1);
    await_req(0);
    give_ack(32'h0000_0013);
    check("t1_icache_rdy", icache_rdy, 1);
    e = exp_q.pop_front();
    check("t1_icache_data", icache_data, e);
    check("t1_stall_c2", stall_cnt, 2);
    tick(1);
    check("t1_stall_c3", stall_cnt, 2);
    check("t1_refetch_req", mem_if.mem_req, 1);
    check("t1_refetch_addr", mem_if.mem_addr, 32'h0);

    // Both ports pending: data first, stray ack in IDLE, then fetch
    reset = 1'b1;
    set_inputs(32'h10, 1'b1, 1'b0, 32'h100, 32'h0);
    tick(2);
    reset = 1'b0;
    req_q.push_back(req(1'b0, 32'h100, 32'h0));
    req_q.push_back(req(1'b0, 32'h10, 32'h0));
    exp_q.push_back(32'hAA);
    exp_q.push_back(32'hBB);
    tick(1);
    await_req(2);
    give_ack(32'hAA);
    check("t2_dcache_rdy", dcache_rdy, 1);
    check("t2_icache_rdy_lo", icache_rdy, 0);
    dexp = exp_q.pop_front();
    check("t2_dcache_rdata", dcache_rdata, dexp);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hFFFF_FFFF;
    tick(1);
    mem_if.mem_ack   = 1'b0;
    check("t2_stray_dbuf", dcache_rdata, dexp);
    check("t2_stray_irdy", icache_rdy, 0);
    await_req(2);
    check("t2_dcache_rdy_held", dcache_rdy, 1);
    give_ack(32'hBB);
    check("t2_icache_rdy", icache_rdy, 1);
    e = exp_q.pop_front();
    check("t2_icache_data", icache_data, e);
    check("t2_dcache_rdy_adv", dcache_rdy, 1);
    check("t2_dcache_rdata_adv", dcache_rdata, dexp);
    tick(1);
    check("t2_after_adv_drdy", dcache_rdy, 0);
    check("t2_after_adv_addr", mem_if.mem_addr, 32'h100);

    // Store held across three wait cycles, then the fetch
    reset = 1'b1;
    set_inputs(32'h50, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    tick(2);
    reset = 1'b0;
    req_q.push_back(req(1'b1, 32'h200, 32'hDEAD_BEEF));
    req_q.push_back(req(1'b0, 32'h50, 32'h0));
    tick(1);
    await_req(3);
    give_ack($urandom);
    check("t3_store_rdy", dcache_rdy, 1);
    await_req(1);
    r = $urandom_range(32'hFFFF, 1);
    exp_q.push_back(r);
    give_ack(r);
    check("t3_icache_rdy", icache_rdy, 1);
    e = exp_q.pop_front();
    check("t3_icache_data", icache_data, e);

    // Tag change before advance: stale entry discarded and re-issued
    reset = 1'b1;
    set_inputs(32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(2);
    reset = 1'b0;
    req_q.push_back(req(1'b0, 32'h20, 32'h0));
    tick(1);
    await_req(1);
    icache_addr = 32'h40;
    req_q.push_back(req(1'b0, 32'h40, 32'h0));
    give_ack(32'h1234);
    check("t4_stale_rdy", icache_rdy, 0);
    tick(1);
    check("t4_reissue_addr", mem_if.mem_addr, 32'h40);
    check("t4_reissue_rdy", icache_rdy, 0);
    await_req(0);
    exp_q.push_back(32'h5678);
    give_ack(32'h5678);
    check("t4_new_rdy", icache_rdy, 1);
    e = exp_q.pop_front();
    check("t4_new_data", icache_data, e);

    // Reset in D_BUSY with a late ack
    reset = 1'b1;
    set_inputs(32'h60, 1'b1, 1'b0, 32'h300, 32'h0);
    tick(2);
    reset = 1'b0;
    req_q.push_back(req(1'b0, 32'h300, 32'h0));
    tick(1);
    await_req(1);
    check("t5_dbusy", dbg_state, 2);
    reset = 1'b1;
    tick(1);
    check("t5_req_after_rst", mem_if.mem_req, 0);
    check("t5_stall_rst", stall_cnt, 0);
    tick(1);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hCAFE;
    tick(1);
    mem_if.mem_ack   = 1'b0;
    check("t5_late_req", mem_if.mem_req, 0);
    check("t5_late_irdy", icache_rdy, 0);
    check("t5_late_drdy", dcache_rdy, 0);
    check("t5_late_state", dbg_state, 0);
    check("t5_late_dbuf", dcache_rdata, 0);
    check("t5_late_stall", stall_cnt, 0);
    dcache_en = 1'b0;
    #1;
    check("t5_drdy_noen", dcache_rdy, 1);
    reset = 1'b0;
    req_q.push_back(req(1'b0, 32'h60, 32'h0));
    tick(1);
    await_req(0);
    exp_q.push_back(32'h77);
    give_ack(32'h77);
    check("t5_fetch_rdy", icache_rdy, 1);
    e = exp_q.pop_front();
    check("t5_fetch_data", icache_data, e);

    check("req_q_drained", req_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
